pc_seq_ctrl: RTL
================

// Module: pc_seq_ctrl
// PURPOSE
//   Instruction-sequencing FSM that drives the program-counter block (4-bit reg + incrementer + load mux).
//   The PC block has no enable: it increments on every clk unless set_pc=1. This block therefore owns
//   set_pc/PC_INIT every cycle: it holds, loads or advances the PC, runs the instruction-memory fetch
//   handshake, hands the instruction to decode and accepts branch/halt results from execute.
// PARAMETERS
//   ADDR_W     4    PC / memory address width (matches PC block)
//   INSTR_W    8    instruction word width
//   RESET_VEC  4'h0 PC value loaded at reset
//   TIMEOUT    15   max cycles to wait for mem_ack before fetch error (1..255)
// PORTS
//   clk          in   1        system clock, all state on rising edge
//   rst          in   1        synchronous, active-high reset
//   PC_CURR      in   ADDR_W   current PC from PC block
//   set_pc       out  1        1 = PC block loads PC_INIT next edge; 0 = PC block increments
//   PC_INIT      out  ADDR_W   load value to PC block
//   mem_req      out  1        instruction read request (held until ack)
//   MEM_ADDR     out  ADDR_W   read address (= PC_CURR)
//   mem_ack      in   1        read data valid this cycle
//   MEM_DATA     in   INSTR_W  read data
//   INSTR        out  INSTR_W  instruction register to decode
//   instr_valid  out  1        1-cycle pulse: INSTR newly loaded
//   exec_done    in   1        execute finished current instruction
//   branch_taken in   1        with exec_done: load BR_TARGET
//   BR_TARGET    in   ADDR_W   branch destination
//   halt         in   1        with exec_done: stop after this instruction
//   resume       in   1        leave HALT
//   halted       out  1        1 while in HALT
//   fetch_err    out  1        sticky: fetch timed out; cleared only by rst
//   RETIRED      out  8        retired-instruction count, saturates at 8'hFF
// BEHAVIOUR
//   States: RST, FETCH, EXEC, HALT. Encoding free. set_pc, PC_INIT, MEM_ADDR combinational; all else registered.
//   rst=1 (any state, mid-fetch included): set_pc=1, PC_INIT=RESET_VEC (PC loads at same edge); next state RST;
//     INSTR=0, instr_valid=0, mem_req=0, halted=0, fetch_err=0, RETIRED=0, wait counter=0.
//   RST: set_pc=1, PC_INIT=RESET_VEC; -> FETCH next edge.
//   FETCH: mem_req=1, MEM_ADDR=PC_CURR, set_pc=1, PC_INIT=PC_CURR (PC held).
//     mem_ack=1: INSTR<=MEM_DATA, instr_valid<=1 (high exactly first EXEC cycle), counter<=0, -> EXEC.
//     mem_ack=0: counter++; on the edge where counter reaches TIMEOUT with no ack: fetch_err<=1, -> HALT.
//     Zero-wait memory (ack in first FETCH cycle) gives 1 FETCH cycle per instruction.
//   EXEC: mem_req=0. exec_done=0: set_pc=1, PC_INIT=PC_CURR (hold).
//     exec_done=1: RETIRED++ (sat); branch_taken=1: set_pc=1, PC_INIT=BR_TARGET; else set_pc=0 (PC+1,
//       4'hF wraps to 4'h0 in PC block). Then halt=1 -> HALT, else -> FETCH.
//     halt and branch_taken together: PC still takes BR_TARGET, then HALT. exec_done in instr_valid cycle legal.
//   HALT: halted=1, set_pc=1, PC_INIT=PC_CURR. resume=1 and fetch_err=0 -> FETCH (halted=0 next cycle).
//     resume ignored while fetch_err=1 (rst only exit).
//   Inputs exec_done/branch_taken/halt ignored outside EXEC; mem_ack ignored outside FETCH.
//   Never set_pc=0 except EXEC with exec_done=1 and branch_taken=0 (no unintended PC drift).
// TESTING
//   1 rst 2 cycles, release -> PC=0, FETCH with mem_req=1, MEM_ADDR=0; RETIRED=0, fetch_err=0.
//   2 zero-wait ack, exec_done every EXEC, no branch, 17 instrs -> addresses 0..F,0 (wrap); RETIRED=17.
//   3 ack after 3 wait cycles at PC=5 -> PC stays 5 all FETCH cycles; INSTR=MEM_DATA, 1-cycle instr_valid.
//   4 PC=3, exec_done+branch_taken, BR_TARGET=A -> next MEM_ADDR=A; with halt also =1 -> HALT, PC=A held
//     over 10 cycles; resume -> fetch from A.
//   5 no ack for TIMEOUT cycles -> fetch_err=1, halted=1; resume ignored; rst clears and refetches from 0.
//   6 rst asserted mid-FETCH (mem_req=1) and mid-EXEC -> next cycle mem_req=0, PC=RESET_VEC, state RST.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: instruction-sequencing FSM that owns the PC block's load control every cycle.
// Latency: a zero-wait fetch costs one FETCH cycle; INSTR/instr_valid appear on the first EXEC cycle.
// Flow control: mem_req is held until mem_ack; EXEC waits for exec_done; HALT waits for resume.
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   PC_CURR / set_pc, PC_INIT  PC block feedback and load control (set_pc=0 lets the PC increment)
//   mem_req, MEM_ADDR          instruction fetch request/address; mem_ack, MEM_DATA fetch response
//   INSTR, instr_valid         instruction register and one-cycle "newly loaded" pulse to decode
//   exec_done, branch_taken,
//   BR_TARGET, halt            execute results, sampled only in EXEC
//   resume / halted            leave HALT / HALT status
//   fetch_err                  sticky fetch-timeout flag, cleared only by rst
//   RETIRED                    saturating retired-instruction count
module pc_seq_ctrl #(
   parameter int                ADDR_W    = 4,
   parameter int                INSTR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                TIMEOUT   = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  PC_CURR,
   output logic               set_pc,
   output logic [ADDR_W-1:0]  PC_INIT,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  MEM_ADDR,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] MEM_DATA,
   output logic [INSTR_W-1:0] INSTR,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  BR_TARGET,
   input  logic               halt,
   input  logic               resume,
   output logic               halted,
   output logic               fetch_err,
   output logic [7:0]         RETIRED
);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Value of the wait counter in the last FETCH cycle allowed before timing out.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic               mem_req_q, halted_q;
   logic               fetch_err_q, fetch_err_d;
   logic [7:0]         wait_q, wait_d;
   logic [7:0]         retired_q, retired_d;

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      fetch_err_d   = fetch_err_q;
      wait_d        = '0;
      retired_d     = retired_q;
      // The PC block increments unless told to load, so the default is to reload the current PC.
      set_pc        = 1'b1;
      PC_INIT       = PC_CURR;

      case (state_q)
         ST_RST: begin
            PC_INIT = RESET_VEC;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ack) begin
               instr_d       = MEM_DATA;
               instr_valid_d = 1'b1;
               state_d       = ST_EXEC;
            end else if (wait_q == WAIT_LAST) begin
               fetch_err_d = 1'b1;
               state_d     = ST_HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               if (retired_q != 8'hFF) begin
                  retired_d = retired_q + 8'd1;
               end
               // The only place the PC is allowed to advance on its own.
               if (branch_taken) begin
                  PC_INIT = BR_TARGET;
               end else begin
                  set_pc = 1'b0;
               end
               state_d = halt ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            if (resume && !fetch_err_q) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_RST;
      endcase

      // Reset reloads the PC on the same edge regardless of the current state.
      if (rst) begin
         set_pc  = 1'b1;
         PC_INIT = RESET_VEC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RST;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         mem_req_q     <= 1'b0;
         halted_q      <= 1'b0;
         fetch_err_q   <= 1'b0;
         wait_q        <= '0;
         retired_q     <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         // Registered status flags track the state being entered.
         mem_req_q     <= (state_d == ST_FETCH);
         halted_q      <= (state_d == ST_HALT);
         fetch_err_q   <= fetch_err_d;
         wait_q        <= wait_d;
         retired_q     <= retired_d;
      end
   end

   assign MEM_ADDR    = PC_CURR;
   assign mem_req     = mem_req_q;
   assign INSTR       = instr_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;
   assign fetch_err   = fetch_err_q;
   assign RETIRED     = retired_q;

endmodule
